trisc_ctrl_seq: RTL and testbench

//  Parametrised TRISC control sequencer; generation 2 of the fixed one-hot-decoded control FSM.

---
 rtl/trisc_pkg.sv | 78 +++++++
 rtl/trisc_ctrl_seq_if.sv | 19 +
 rtl/trisc_wait_ctr.sv | 31 +++
 rtl/trisc_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_trisc_ctrl_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trisc_pkg.sv
// trisc_pkg: shared definitions for the TRISC control sequencer.
//   - opcode encodings (4-bit; wider opcode fields zero-extend them)
//   - sequencer state encodings and registered opcode class
//   - C-line bit indices and ALU-mode mapping onto C12/C13
package trisc_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0110;
  localparam logic [3:0] OP_CLR = 4'b0111;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_JPZ = 4'b1001;
  localparam logic [3:0] OP_JPN = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // 15 states in 4 bits; encoding 4'hF is unused and recovers to S_INIT.
  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_R = 4'd2,
    S_DECODE  = 4'd3,
    S_EX_INC  = 4'd4,
    S_EX_CLR  = 4'd5,
    S_EX_JMP  = 4'd6,
    S_MA      = 4'd7,
    S_MR      = 4'd8,
    S_LD_WB   = 4'd9,
    S_MW      = 4'd10,
    S_AL_GAP  = 4'd11,
    S_AL_OP   = 4'd12,
    S_AL_WB   = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  // Memory-referencing instruction class, captured in DECODE.
  typedef enum logic [2:0] {
    CLS_LD  = 3'd0,
    CLS_ST  = 3'd1,
    CLS_ADD = 3'd2,
    CLS_SUB = 3'd3,
    CLS_XOR = 3'd4
  } op_class_t;

  // C-line bit indices (C6 is reserved and never driven).
  localparam int C0  = 0;
  localparam int C1  = 1;
  localparam int C2  = 2;
  localparam int C3  = 3;
  localparam int C4  = 4;
  localparam int C5  = 5;
  localparam int C7  = 7;
  localparam int C8  = 8;
  localparam int C9  = 9;
  localparam int C10 = 10;
  localparam int C11 = 11;
  localparam int C12 = 12;
  localparam int C13 = 13;
  localparam int C14 = 14;

  // ALU mode as {C13, C12}.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_XOR = 2'b10
  } alu_mode_t;

  function automatic alu_mode_t alu_mode_of(op_class_t cls);
    case (cls)
      CLS_SUB: return ALU_SUB;
      CLS_XOR: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/trisc_ctrl_seq_if.sv
// trisc_ctrl_seq_if: IR/flag inputs and C-line outputs of the control sequencer.
//   opcode, zf, nf   : from instruction / flag registers (master -> slave)
//   ctrl             : C0..C14 control vector to the datapath (slave -> master)
//   halted           : high while the sequencer sits in HALT
//   illegal_op       : sticky unmapped-opcode flag
interface trisc_ctrl_seq_if #(
  parameter int OPC_W  = 4,
  parameter int CTRL_W = 15
);
  logic [OPC_W-1:0]  opcode;
  logic              zf;
  logic              nf;
  logic [CTRL_W-1:0] ctrl;
  logic              halted;
  logic              illegal_op;

  modport master (output opcode, zf, nf, input ctrl, halted, illegal_op);
  modport slave  (input opcode, zf, nf, output ctrl, halted, illegal_op);
endinterface

// File: rtl/trisc_wait_ctr.sv
// trisc_wait_ctr: 4-bit load/decrement counter timing memory wait states.
//   clk      : sequencer clock; counts on the FALLING edge like the sequencer
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded, MEM_WAIT-1
//   dec      : decrement; saturates at 0 so the count never wraps
//   zero     : count is 0, the owning wait state exits on this edge
module trisc_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/trisc_ctrl_seq.sv
// trisc_ctrl_seq: TRISC control sequencer (Moore FSM, falling-edge clocked).
//   SysClock   : system clock, all state changes on its falling edge
//   StartStop  : asynchronous active-low reset, forces INIT
//   bus        : slave side of trisc_ctrl_seq_if (opcode/zf/nf in; ctrl,
//                halted, illegal_op out)
// Parameters: OPC_W opcode width (>= 4), MEM_WAIT cycles per memory access
// (1..15), CTRL_W control vector width.
module trisc_ctrl_seq
  import trisc_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int MEM_WAIT = 2,
  parameter int CTRL_W   = 15
) (
  input logic             SysClock,
  input logic             StartStop,
  trisc_ctrl_seq_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t            state_q, state_d;
  op_class_t         cls_q, cls_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              halted_q;
  logic              ill_q, ill_d;
  logic              wait_zero, wait_load, wait_dec;
  alu_mode_t         alu_mode;

  // Counter is reloaded only on entry to a wait state and drains while there.
  assign wait_load = (state_d != state_q) && (state_d inside {S_FETCH_R, S_MR, S_MW});
  assign wait_dec  = (state_q inside {S_FETCH_R, S_MR, S_MW}) && !wait_zero;

  trisc_wait_ctr u_wait (
    .clk      (SysClock),
    .rst_n    (StartStop),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = S_INIT;
    cls_d   = cls_q;
    ill_d   = 1'b0;
    case (state_q)
      S_INIT:    state_d = S_FETCH_A;
      S_FETCH_A: state_d = S_FETCH_R;
      S_FETCH_R: state_d = wait_zero ? S_DECODE : S_FETCH_R;
      S_DECODE: begin
        state_d = S_FETCH_A;
        case (bus.opcode)
          OPC_W'(OP_LDA): begin state_d = S_MA; cls_d = CLS_LD;  end
          OPC_W'(OP_STA): begin state_d = S_MA; cls_d = CLS_ST;  end
          OPC_W'(OP_ADD): begin state_d = S_MA; cls_d = CLS_ADD; end
          OPC_W'(OP_SUB): begin state_d = S_MA; cls_d = CLS_SUB; end
          OPC_W'(OP_XOR): begin state_d = S_MA; cls_d = CLS_XOR; end
          OPC_W'(OP_INC): state_d = S_EX_INC;
          OPC_W'(OP_CLR): state_d = S_EX_CLR;
          OPC_W'(OP_JMP): state_d = S_EX_JMP;
          OPC_W'(OP_JPZ): state_d = bus.zf ? S_EX_JMP : S_FETCH_A;
          OPC_W'(OP_JPN): state_d = bus.nf ? S_EX_JMP : S_FETCH_A;
          OPC_W'(OP_HLT): state_d = S_HALT;
          default:        ill_d   = 1'b1;
        endcase
      end
      S_EX_INC, S_EX_CLR, S_EX_JMP: state_d = S_FETCH_A;
      S_MA:     state_d = (cls_q == CLS_ST) ? S_MW : S_MR;
      S_MR: begin
        if (!wait_zero)           state_d = S_MR;
        else if (cls_q == CLS_LD) state_d = S_LD_WB;
        else                      state_d = S_AL_GAP;
      end
      S_LD_WB:  state_d = S_FETCH_A;
      S_MW:     state_d = wait_zero ? S_FETCH_A : S_MW;
      S_AL_GAP: state_d = S_AL_OP;
      S_AL_OP:  state_d = S_AL_WB;
      S_AL_WB:  state_d = S_FETCH_A;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  assign alu_mode = alu_mode_of(cls_d);

  // ctrl is decoded from the NEXT state and registered, so the output pins
  // carry the decode of the current state straight from flops.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_INIT:    ctrl_d[C0] = 1'b1;
      S_FETCH_A: ctrl_d[C3] = 1'b1;
      S_FETCH_R: begin ctrl_d[C3] = 1'b1; ctrl_d[C4] = 1'b1; end
      S_DECODE:  begin ctrl_d[C2] = 1'b1; ctrl_d[C3] = 1'b1; ctrl_d[C7] = 1'b1; end
      S_EX_INC:  ctrl_d[C9]  = 1'b1;
      S_EX_CLR:  ctrl_d[C8]  = 1'b1;
      S_EX_JMP:  ctrl_d[C1]  = 1'b1;
      S_MR:      ctrl_d[C4]  = 1'b1;
      S_LD_WB:   ctrl_d[C11] = 1'b1;
      S_MW:      begin ctrl_d[C4] = 1'b1; ctrl_d[C5] = 1'b1; end
      S_AL_OP: begin
        ctrl_d[C10] = 1'b1;
        ctrl_d[C12] = alu_mode[0];
        ctrl_d[C13] = alu_mode[1];
      end
      S_AL_WB: begin
        ctrl_d[C14] = 1'b1;
        ctrl_d[C12] = alu_mode[0];
        ctrl_d[C13] = alu_mode[1];
      end
      default: ;
    endcase
  end

  always_ff @(negedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      // NOTE: reset loads the INIT decode (C0), not all-zero, so ctrl stays
      // consistent with the state register from the moment reset asserts.
      state_q  <= S_INIT;
      cls_q    <= CLS_LD;
      ctrl_q   <= CTRL_W'(1) << C0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, regardless of statement order.
      state_q  <= state_d;
      cls_q    <= cls_d;
      ctrl_q   <= ctrl_d;
      halted_q <= (state_d == S_HALT);
      ill_q    <= ill_q | ill_d;
    end
  end

  assign bus.ctrl       = ctrl_q;
  assign bus.halted     = halted_q;
  assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// tb_trisc_ctrl_seq: three sequencers (MEM_WAIT = 2, 1, 5) run directed then
// random instruction streams; a per-instruction cycle model predicts the
// {ctrl, halted, illegal_op} word seen on each rising edge.
module tb_trisc_ctrl_seq;

  localparam int NDUT    = 3;
  localparam int NINS    = 40;
  localparam int NDIR    = 15;
  localparam int ABORT_K = 13;
  localparam int MAX_CYC = 20000;

  localparam int M_RST  = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_DONE = 3;

  typedef struct packed {
    logic [14:0] ctrl;
    logic        halted;
    logic        ill;
    logic        dec;   // this is the DECODE cycle: real opcode must be driven
    logic        mr0;   // first MR cycle: candidate point for a mid-access reset
  } exp_t;
  typedef exp_t exp_q_t [$];

  function automatic int w_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_a    [NDUT];
  logic [3:0]  op_a     [NDUT];
  logic        zf_a     [NDUT];
  logic        nf_a     [NDUT];
  logic [14:0] ctrl_a   [NDUT];
  logic        halted_a [NDUT];
  logic        ill_a    [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = w_of(g);
    trisc_ctrl_seq_if #(.OPC_W(4), .CTRL_W(15)) bus ();
    assign bus.opcode  = op_a[g];
    assign bus.zf      = zf_a[g];
    assign bus.nf      = nf_a[g];
    assign ctrl_a[g]   = bus.ctrl;
    assign halted_a[g] = bus.halted;
    assign ill_a[g]    = bus.illegal_op;
    trisc_ctrl_seq #(.OPC_W(4), .MEM_WAIT(W), .CTRL_W(15)) dut (
      .SysClock  (clk),
      .StartStop (rst_a[g]),
      .bus       (bus)
    );
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [14:0] cl(int i);
    return 15'(1) << i;
  endfunction

  function automatic bit legal(logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
  endfunction

  function automatic exp_t mk(logic [14:0] c, logic h, logic il, logic d, logic m);
    exp_t e;
    e.ctrl = c; e.halted = h; e.ill = il; e.dec = d; e.mr0 = m;
    return e;
  endfunction

  // Expected outputs from the FETCH_A cycle up to (not including) the next
  // FETCH_A. illegal_op flips after DECODE, so post-decode cycles use il1.
  function automatic exp_q_t model_instr(int w, logic [3:0] op, logic z, logic n, logic il0);
    exp_q_t q;
    logic il1;
    logic [14:0] md;
    il1 = il0 | !legal(op);
    md  = (op == 4'h3) ? cl(12) : (op == 4'h4) ? cl(13) : 15'h0;
    q.push_back(mk(cl(3), 1'b0, il0, 1'b0, 1'b0));
    for (int i = 0; i < w; i++) q.push_back(mk(cl(3) | cl(4), 1'b0, il0, 1'b0, 1'b0));
    q.push_back(mk(cl(2) | cl(3) | cl(7), 1'b0, il0, 1'b1, 1'b0));
    case (op)
      4'h6: q.push_back(mk(cl(9), 1'b0, il1, 1'b0, 1'b0));
      4'h7: q.push_back(mk(cl(8), 1'b0, il1, 1'b0, 1'b0));
      4'h8: q.push_back(mk(cl(1), 1'b0, il1, 1'b0, 1'b0));
      4'h9: if (z) q.push_back(mk(cl(1), 1'b0, il1, 1'b0, 1'b0));
      4'hA: if (n) q.push_back(mk(cl(1), 1'b0, il1, 1'b0, 1'b0));
      4'h0: begin
        q.push_back(mk(15'h0, 1'b0, il1, 1'b0, 1'b0));
        for (int i = 0; i < w; i++) q.push_back(mk(cl(4), 1'b0, il1, 1'b0, 1'(i == 0)));
        q.push_back(mk(cl(11), 1'b0, il1, 1'b0, 1'b0));
      end
      4'h1: begin
        q.push_back(mk(15'h0, 1'b0, il1, 1'b0, 1'b0));
        for (int i = 0; i < w; i++) q.push_back(mk(cl(4) | cl(5), 1'b0, il1, 1'b0, 1'b0));
      end
      4'h2, 4'h3, 4'h4: begin
        q.push_back(mk(15'h0, 1'b0, il1, 1'b0, 1'b0));
        for (int i = 0; i < w; i++) q.push_back(mk(cl(4), 1'b0, il1, 1'b0, 1'(i == 0)));
        q.push_back(mk(15'h0, 1'b0, il1, 1'b0, 1'b0));
        q.push_back(mk(cl(10) | md, 1'b0, il1, 1'b0, 1'b0));
        q.push_back(mk(cl(14) | md, 1'b0, il1, 1'b0, 1'b0));
      end
      4'hF: q.push_back(mk(15'h0, 1'b1, il1, 1'b0, 1'b0));
      default: ;
    endcase
    return q;
  endfunction

  function automatic logic [16:0] obs(int g);
    return {ctrl_a[g], halted_a[g], ill_a[g]};
  endfunction

  // ---------------- stimulus bookkeeping ----------------
  exp_q_t     q         [NDUT];
  logic       ill       [NDUT];
  int         k         [NDUT];
  int         mode      [NDUT];
  int         cnt       [NDUT];
  logic [3:0] cur_op    [NDUT];
  logic       cur_z     [NDUT];
  logic       cur_n     [NDUT];
  bit         cur_abort [NDUT];
  bit         rst_chk   [NDUT];

  localparam logic [16:0] RESET_OBS = {15'h0001, 1'b0, 1'b0};

  task automatic garbage(input int g);
    op_a[g] = 4'($urandom_range(0, 15));
    zf_a[g] = 1'($urandom_range(0, 1));
    nf_a[g] = 1'($urandom_range(0, 1));
  endtask

  task automatic next_instr(input int g);
    logic [5:0] d;
    if (k[g] == NINS) begin
      mode[g] = M_DONE;
      return;
    end
    if (k[g] < NDIR) begin
      case (k[g])
        0:  d = {4'h2, 2'b00};  // ADD
        1:  d = {4'h9, 2'b10};  // JPZ taken (nf=0)
        2:  d = {4'h9, 2'b01};  // JPZ not taken (nf=1)
        3:  d = {4'hA, 2'b01};  // JPN taken (zf=0)
        4:  d = {4'hA, 2'b10};  // JPN not taken (zf=1)
        5:  d = {4'h3, 2'b00};  // SUB
        6:  d = {4'h4, 2'b00};  // XOR
        7:  d = {4'h0, 2'b00};  // LDA
        8:  d = {4'h1, 2'b00};  // STA
        9:  d = {4'h5, 2'b00};  // illegal
        10: d = {4'h6, 2'b00};  // INC
        11: d = {4'h7, 2'b00};  // CLR
        12: d = {4'h8, 2'b00};  // JMP
        13: d = {4'h0, 2'b00};  // LDA, reset mid-MR
        default: d = {4'hF, 2'b00};  // HLT
      endcase
      cur_op[g] = d[5:2];
      cur_z[g]  = d[1];
      cur_n[g]  = d[0];
    end else begin
      cur_op[g] = 4'($urandom_range(0, 15));
      cur_z[g]  = 1'($urandom_range(0, 1));
      cur_n[g]  = 1'($urandom_range(0, 1));
    end
    cur_abort[g] = (k[g] == ABORT_K) || (k[g] >= NDIR && $urandom_range(0, 7) == 0);
    q[g]   = model_instr(w_of(g), cur_op[g], cur_z[g], cur_n[g], ill[g]);
    ill[g] = ill[g] | !legal(cur_op[g]);
    k[g]++;
    mode[g] = M_RUN;
  endtask

  initial begin : stim
    exp_t e;
    int   cyc;
    bit   busy;

    // Literal expectations that pin the model to hand-derived sequences.
    begin : pin
      exp_q_t p;
      logic [14:0] add_ref [10];
      add_ref = '{15'h0008, 15'h0018, 15'h0018, 15'h008C, 15'h0000,
                  15'h0010, 15'h0010, 15'h0000, 15'h0400, 15'h4000};
      p = model_instr(2, 4'h2, 1'b0, 1'b0, 1'b0);
      check("pin add w2 length", 32'(p.size()), 32'd10);
      for (int i = 0; i < 10; i++)
        check($sformatf("pin add w2 ctrl[%0d]", i), 32'(p[i].ctrl), 32'(add_ref[i]));
      p = model_instr(2, 4'h3, 1'b0, 1'b0, 1'b0);
      check("pin sub w2 al_op", 32'(p[8].ctrl), 32'h1400);
      p = model_instr(5, 4'h0, 1'b0, 1'b0, 1'b0);
      check("pin lda w5 length", 32'(p.size()), 32'd14);
      p = model_instr(1, 4'h1, 1'b0, 1'b0, 1'b0);
      check("pin sta w1 length", 32'(p.size()), 32'd5);
      p = model_instr(2, 4'h9, 1'b0, 1'b1, 1'b0);
      check("pin jpz nt length", 32'(p.size()), 32'd4);
      p = model_instr(2, 4'h9, 1'b1, 1'b0, 1'b0);
      check("pin jpz t jmp", 32'(p[4].ctrl), 32'h0002);
    end

    for (int g = 0; g < NDUT; g++) begin
      rst_a[g] = 1'b1;
      op_a[g]  = 4'h0;
      zf_a[g]  = 1'b0;
      nf_a[g]  = 1'b0;
      ill[g]   = 1'b0;
      k[g]     = 0;
      mode[g]  = M_RST;
      cnt[g]   = 3;
    end
    #1;
    for (int g = 0; g < NDUT; g++) rst_a[g] = 1'b0;

    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < MAX_CYC) begin
      @(posedge clk);
      cyc++;
      for (int g = 0; g < NDUT; g++) begin
        rst_chk[g] = 1'b0;
        case (mode[g])
          M_RST: begin
            check($sformatf("w%0d reset k%0d", w_of(g), k[g]), 32'(obs(g)), 32'(RESET_OBS));
            garbage(g);
            cnt[g]--;
            if (cnt[g] == 0) begin
              rst_a[g] = 1'b1;
              next_instr(g);
            end
          end
          M_RUN: begin
            e = q[g].pop_front();
            check($sformatf("w%0d op%h k%0d left%0d", w_of(g), cur_op[g], k[g], q[g].size()),
                  32'(obs(g)), 32'({e.ctrl, e.halted, e.ill}));
            if (e.dec) begin
              op_a[g] = cur_op[g];
              zf_a[g] = cur_z[g];
              nf_a[g] = cur_n[g];
            end else begin
              garbage(g);
            end
            if (e.mr0 && cur_abort[g]) begin
              rst_a[g]   = 1'b0;
              rst_chk[g] = 1'b1;
              ill[g]     = 1'b0;
              q[g].delete();
              mode[g]    = M_RST;
              cnt[g]     = 2;
            end else if (q[g].size() == 0) begin
              if (cur_op[g] == 4'hF) begin
                mode[g] = M_HALT;
                cnt[g]  = 20;
              end else begin
                next_instr(g);
              end
            end
          end
          M_HALT: begin
            check($sformatf("w%0d halt k%0d left%0d", w_of(g), k[g], cnt[g]),
                  32'(obs(g)), 32'({15'h0000, 1'b1, ill[g]}));
            garbage(g);
            cnt[g]--;
            if (cnt[g] == 0) begin
              rst_a[g]   = 1'b0;
              rst_chk[g] = 1'b1;
              ill[g]     = 1'b0;
              mode[g]    = M_RST;
              cnt[g]     = 2;
            end
          end
          default: ;
        endcase
      end
      #1;
      for (int g = 0; g < NDUT; g++)
        if (rst_chk[g])
          check($sformatf("w%0d async reset k%0d", w_of(g), k[g]), 32'(obs(g)), 32'(RESET_OBS));
      busy = 1'b0;
      for (int g = 0; g < NDUT; g++)
        if (mode[g] != M_DONE) busy = 1'b1;
    end

    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL run budget: got %0d cycles without completion, required completion within %0d", cyc, MAX_CYC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
